// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall detection and CGRA offload sequencing
module hazard_ctrl #(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 10
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             cgra_issue_i,
    input  logic             cgra_done_i,
    output logic             hazardpc_o,
    output logic             ifid_stall_o,
    output logic             idex_flush_o,
    output logic             cgra_start_o,
    output logic             cgra_busy_o,
    output logic             cgra_wb_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cgra_cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, cycles_nxt;
    logic             timeout_nxt;
    logic             lu;
    logic             stall;

    assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cycles_nxt  = cgra_cycles_o;
        timeout_nxt = timeout_o;
        stall       = 1'b1;
        case (state)
            S_IDLE: begin
                // Load-use wins; a blocked CGRA op simply re-presents next cycle.
                stall = lu | cgra_issue_i;
                if (!lu && cgra_issue_i) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_nxt     = '0;
                timeout_nxt = 1'b0;
                if (cgra_done_i) begin
                    state_nxt  = S_DRAIN;
                    cycles_nxt = '0;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cgra_done_i) begin
                    state_nxt  = S_DRAIN;
                    cycles_nxt = cnt_inc;
                end else if (cnt_inc == TMO) begin
                    state_nxt   = S_DRAIN;
                    timeout_nxt = 1'b1;
                    cycles_nxt  = TMO;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state         <= S_IDLE;
            cnt           <= '0;
            timeout_o     <= 1'b0;
            cgra_cycles_o <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            timeout_o     <= timeout_nxt;
            cgra_cycles_o <= cycles_nxt;
        end
    end

    assign hazardpc_o   = stall;
    assign ifid_stall_o = stall;
    assign idex_flush_o = stall;
    assign cgra_start_o = (state == S_LAUNCH);
    assign cgra_wb_o    = (state == S_DRAIN);
    assign cgra_busy_o  = (state != S_IDLE);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the PC stall input (`hazardpc`), the IF/ID hold and the ID/EX bubble for the RISC-V core. It detects load-use hazards combinationally. It also sequences each CGRA offload: it stalls fetch, pulses the CGRA start, waits for CGRA done or a timeout, then holds one drain cycle for result writeback. It sits between the ID/EX stage decode and the PC register, and forms the initiator side of the CGRA start/done handshake.

## Interface
- `TIMEOUT`, 1000: maximum CGRA wait cycles before forced abort; must be ≥2 and ≤ 2^`CNT_W`−1.
- `CNT_W`, 10: width of the wait counter and `cgra_cycles_o`.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `start_i`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `id_rs1_i`  in  5  rs1 index of the instruction in ID.
- `id_rs2_i`  in  5  rs2 index of the instruction in ID.
- `ex_rd_i`  in  5  rd index of the instruction in EX.
- `ex_memread_i`  in  1  EX instruction is a load.
- `cgra_issue_i`  in  1  ID instruction is a CGRA custom op.
- `cgra_done_i`  in  1  CGRA completion; a level is accepted, a pulse is sufficient.
- `hazardpc_o`  out  1  stall PC (PC holds when 1).
- `ifid_stall_o`  out  1  hold the IF/ID register.
- `idex_flush_o`  out  1  insert a bubble into ID/EX.
- `cgra_start_o`  out  1  one-cycle CGRA launch pulse.
- `cgra_busy_o`  out  1  FSM is not in IDLE.
- `cgra_wb_o`  out  1  CGRA result writeback enable, asserted in DRAIN only.
- `timeout_o`  out  1  sticky: the last CGRA op was aborted by timeout.
- `cgra_cycles_o`  out  `CNT_W`  WAIT-cycle count of the last completed or aborted op.

## Operation
- **Load-use hazard**: `lu = ex_memread_i & (ex_rd_i != 0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i)`. This term is evaluated in IDLE only.
- **Stall group**: `hazardpc_o`, `ifid_stall_o` and `idex_flush_o` are always equal. The group is called `stall` below.
- **FSM states**: IDLE, LAUNCH, WAIT, DRAIN.
- **IDLE**
  - `stall = lu | cgra_issue_i`.
  - If `lu` is 1, stay in IDLE. Load-use has priority; the CGRA op re-presents next cycle.
  - Else if `cgra_issue_i` is 1, go to LAUNCH.
- **LAUNCH**
  - `stall = 1` and `cgra_start_o = 1`.
  - Clear the counter and clear `timeout_o`.
  - If `cgra_done_i` is 1, go to DRAIN with `cgra_cycles_o` ← 0. Otherwise go to WAIT.
- **WAIT**
  - `stall = 1`; the counter increments each cycle.
  - If `cgra_done_i` is 1, go to DRAIN with `cgra_cycles_o` ← counter+1.
  - Else if counter+1 == `TIMEOUT`, go to DRAIN with `timeout_o` ← 1 and `cgra_cycles_o` ← `TIMEOUT`.
  - `cgra_done_i` wins when it arrives in the same cycle as the timeout.
- **DRAIN**
  - `stall = 1` and `cgra_wb_o = 1`; the next state is always IDLE.
  - `cgra_issue_i` and `cgra_done_i` are ignored.
- **Outputs by state**
  - `cgra_busy_o` = 1 in LAUNCH, WAIT and DRAIN.
  - `cgra_start_o` and `cgra_wb_o` are registered-state decodes, so they are glitch-free.
  - The stall group is combinational, so it can assert in the same cycle as the hazard.
- **Reset** (`start_i` = 0):
  - state = IDLE, counter = 0, `timeout_o` = 0, `cgra_cycles_o` = 0.
  - `cgra_start_o` = `cgra_wb_o` = `cgra_busy_o` = 0.
  - The stall group follows the IDLE equation.
  - Reset mid-operation aborts to IDLE with no start or writeback pulse, and the stall group releases immediately.

## Timing
- **Load-use**: the stall is asserted in the same cycle, for one cycle only. Next cycle the load is in MEM, `ex_memread_i` falls, and the stall drops.
- **CGRA stall sequence**: issue cycle T0 (IDLE) → T1 LAUNCH (start pulse) → T2..Tk WAIT → DRAIN → IDLE.
- **CGRA stall length**: with done first seen in WAIT cycle n (n ≥ 1), the stall lasts n+3 cycles (issue + LAUNCH + n WAIT + DRAIN).
- **Done in LAUNCH**: the stall lasts 3 cycles.
- **Timeout**: the stall lasts `TIMEOUT`+3 cycles.
- **Back-to-back ops**: a new `cgra_issue_i` is accepted in the IDLE cycle right after DRAIN, with no dead cycle.
- **Counter**: it never wraps, because the timeout bounds it to at most `TIMEOUT`−1.

## Test plan
- **Load-use, rs1 match**: `ex_memread_i`=1, `ex_rd_i`=5, `id_rs1_i`=5 for one cycle → stall group = 1 in that cycle only, `cgra_busy_o`=0.
- **Load to x0**: `ex_rd_i`=0, `id_rs2_i`=0, `ex_memread_i`=1 → no stall. With `ex_memread_i`=0 and matching rd → no stall.
- **CGRA op, done after 4 WAIT cycles**:
  - `cgra_issue_i`=1 → `cgra_start_o` is a single pulse in the next cycle.
  - Stall lasts 7 cycles; `cgra_wb_o` pulses in the last stall cycle.
  - `cgra_cycles_o`=4, `timeout_o`=0.
- **Timeout**: `TIMEOUT`=8, done never asserted → DRAIN after 8 WAIT cycles, `timeout_o`=1, `cgra_cycles_o`=8, stall = 11 cycles. The next launch clears `timeout_o`.
- **Priority and edge cases**:
  - `lu` and `cgra_issue_i` both 1 in IDLE → no start pulse that cycle. Launch occurs the following cycle once `lu`=0.
  - Done coincident with the timeout cycle → `timeout_o`=0.
- **Reset mid-WAIT**: drive `start_i`=0 asynchronously between edges → `cgra_busy_o` and the stall group drop immediately (inputs idle). After release there is no `cgra_wb_o`, and `cgra_cycles_o`=0.
